spi_xfer_arbiter: RTL and testbench
===================================

# spi_xfer_arbiter

Round-robin transfer arbiter that shares one SPI master transfer engine between NREQ independent requesters. It grants one requester at a time and forwards that requester's transmit byte. It issues the single-cycle `send_data` start pulse to the SPI slave-select/control logic, waits for the `receive_data` completion pulse, and returns the received byte to the granted requester. It sits between the APB-side client ports and the SPI master control/shifter.

## Interface
- `NREQ`, default 4: number of requesters; 2..8.
- `DW`, default 8: transfer data width.
- `TO_CYCLES`, default 16'd65535: timeout limit in `P_clk` cycles. Only used with `SPI_ARB_TIMEOUT_EN`.

- `P_clk` in 1: system clock; all logic on rising edge.
- `P_rst` in 1: asynchronous, active-low reset.
- `arb_en` in 1: arbitration enable. Low blocks new grants; an in-flight transfer still completes.
- `req` in NREQ: request level per requester.
- `req_wdata` in NREQ*DW: transmit byte. Requester i uses bits [i*DW +: DW].
- `gnt` out NREQ: one-hot grant, held for the whole transaction.
- `done` out NREQ: one-cycle completion pulse to the granted requester.
- `err` out NREQ: one-cycle timeout pulse to the granted requester.
- `rdata` out DW: received byte; valid in the `done` cycle and held until the next `done`.
- `busy` out 1: high in every state except IDLE.
- `tip` in 1: transfer-in-progress from SPI control.
- `receive_data` in 1: byte-complete pulse from SPI control.
- `spi_rdata` in DW: receive shift register contents.
- `send_data` out 1: one-cycle transfer start pulse.
- `spi_wdata` out DW: registered transmit byte to the shifter.

## Operation
- **States:** IDLE, START, WAIT, DONE, DRAIN. Encoding is free.
- **IDLE:** grant when `arb_en` = 1, `|req` = 1 and `tip` = 0.
  - Winner is the first requester with `req` high, searching from `last+1` modulo NREQ.
  - Register `gnt`, `last` = winner, `spi_wdata` = winner slice. Go to START.
- **START:** `send_data` = 1 for exactly this one cycle. Go to WAIT.
- **WAIT:** on `receive_data` = 1, capture `rdata` = `spi_rdata` and go to DONE. Otherwise stay in WAIT.
- **DONE:** `done[winner]` = 1 for one cycle. Clear `gnt`. Go to DRAIN.
- **DRAIN:** hold until `tip` = 0, then go to IDLE. This guarantees slave select is deasserted between transfers.
- **Pointer:** `last` resets to NREQ-1, so requester 0 has first priority.
- **Dropped request:** `req[winner]` falling after the grant is ignored. The transfer completes and `done` still pulses.
- **Stray completion:** `receive_data` outside WAIT is ignored.
- **`req_wdata` changes:** ignored after the grant cycle; `spi_wdata` is held from the grant.
- **Reset (any time, including mid-transfer):**
  - State returns to IDLE and `last` = NREQ-1.
  - `gnt`, `done`, `err` = 0; `rdata`, `spi_wdata` = 0; `send_data`, `busy` = 0.

## Timing
- **Request to start:** `req` high and sampled in IDLE at edge t gives `gnt`, `spi_wdata` and `busy` valid from t+1, with `send_data` = 1 in cycle t+1 only.
- **Completion:** `receive_data` sampled at edge r gives `done` and `rdata` valid in cycle r+1, and `gnt` = 0 from r+2.
- **Back-to-back:** the minimum gap between consecutive `send_data` pulses is the transfer duration plus 3 cycles (DONE, DRAIN, IDLE).
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **`SPI_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches `TO_CYCLES`-1 without `receive_data`: `err[winner]` pulses for one cycle, `gnt` clears, no `done`, state goes to DRAIN.
  - If `receive_data` arrives in the expiry cycle, `receive_data` wins and no `err` is raised.
- **Not defined:** WAIT holds indefinitely, `err` is tied to 0, and the counter is absent.

## Test plan
- **Single requester:** `req` = 4'b0001, `req_wdata[7:0]` = 8'hA5, `receive_data` pulsed with `spi_rdata` = 8'h3C after 32 cycles.
  - Required: `spi_wdata` = 8'hA5, exactly one `send_data` pulse, then `done` = 4'b0001 with `rdata` = 8'h3C.
- **Round-robin fairness:** `req` = 4'b1111 held for 8 transfers.
  - Required grant order 0,1,2,3,0,1,2,3.
- **Drop mid-transfer:** `req[2]` deasserted in WAIT.
  - Required: `done[2]` still pulses once, after which `gnt` = 0.
- **Drain gate:** `tip` held high for 5 cycles after DONE.
  - Required: no new `gnt` or `send_data` until 1 cycle after `tip` falls.
- **Reset mid-WAIT:** assert `P_rst` = 0 with requester 1 granted.
  - Required: all outputs 0 immediately; after release, `req` = 4'b0011 grants requester 0.
- **Timeout (`SPI_ARB_TIMEOUT_EN`, `TO_CYCLES` = 100):** no `receive_data` after the grant.
  - Required: `err` = the granted bit for one cycle, 100 cycles after entering WAIT, with no `done`.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter that shares one SPI master transfer
// engine between NREQ requesters. It grants one requester, forwards that
// requester's transmit byte, pulses send_data, waits for receive_data and
// hands the received byte back with a one-cycle done pulse.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a WAIT-state timeout
// (err pulse after TO_CYCLES cycles with no receive_data).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick a winner when enabled, requested and tip low
// START | send_data high for this single cycle
// WAIT  | transfer running; wait for receive_data (or timeout)
// DONE  | done pulse to the winner, rdata valid; grant released next
// DRAIN | wait for tip to drop so slave select deasserts between xfers
module spi_xfer_arbiter #(
    parameter int          NREQ      = 4,
    parameter int          DW        = 8,
    parameter logic [15:0] TO_CYCLES = 16'd65535
) (
    input  logic              P_clk,
    input  logic              P_rst,
    input  logic              arb_en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    input  logic              tip,
    input  logic              receive_data,
    input  logic [DW-1:0]     spi_rdata,
    output logic              send_data,
    output logic [DW-1:0]     spi_wdata
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   spi_wdata_q, spi_wdata_d;
    logic            send_data_q, send_data_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [LW-1:0]   win_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]     to_cnt_q, to_cnt_d;
    logic [NREQ-1:0] err_q, err_d;
`endif

    // Round-robin search: first requester with req high, starting at last+1.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = last_q;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = LW'(idx);
            end
        end
    end

    // Next-state and registered-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        spi_wdata_d = spi_wdata_q;
        send_data_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_en && found && !tip) begin
                    state_d     = S_START;
                    gnt_d       = NREQ'(1) << win_idx;
                    last_d      = win_idx;
                    spi_wdata_d = req_wdata[win_idx*DW +: DW];
                    send_data_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (receive_data) begin
                    rdata_d = spi_rdata;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_CYCLES - 16'd1) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!tip) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset returns everything to idle.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            state_q     <= S_IDLE;
            last_q      <= LAST_RST;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            spi_wdata_q <= '0;
            send_data_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            spi_wdata_q <= spi_wdata_d;
            send_data_q <= send_data_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // WAIT-state timeout counter and error pulse register.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign send_data = send_data_q;
    assign spi_wdata = spi_wdata_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter (NREQ=4, DW=8, TO_CYCLES=100).
module tb_spi_xfer_arbiter;

    logic        P_clk = 1'b0;
    logic        P_rst;
    logic        arb_en;
    logic [3:0]  req;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rdata;
    logic        busy;
    logic        tip;
    logic        receive_data;
    logic [7:0]  spi_rdata;
    logic        send_data;
    logic [7:0]  spi_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    spi_xfer_arbiter #(.NREQ(4), .DW(8), .TO_CYCLES(16'd100)) dut (
        .P_clk        (P_clk),
        .P_rst        (P_rst),
        .arb_en       (arb_en),
        .req          (req),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .tip          (tip),
        .receive_data (receive_data),
        .spi_rdata    (spi_rdata),
        .send_data    (send_data),
        .spi_wdata    (spi_wdata)
    );

    always #5 P_clk = ~P_clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [7:0]  srd;
        int          dly;
        logic [3:0]  e_gnt;
        logic [7:0]  e_wd;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] wd;
        logic [7:0] rd;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_send(input string name);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge P_clk);
            n++;
            ok = send_data;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        exp_t e;
        req       = v.req;
        req_wdata = v.wdata;
        sb.push_back('{v.e_gnt, v.e_wd, v.srd});
        wait_send($sformatf("v%0d_start", k));
        e = sb.pop_front();
        chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(e.gnt));
        chk($sformatf("v%0d_wdata", k), 32'(spi_wdata), 32'(e.wd));
        chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
        req_wdata = ~v.wdata;
        @(negedge P_clk);
        chk($sformatf("v%0d_send_once", k), 32'(send_data), 32'd0);
        repeat (v.dly) @(negedge P_clk);
        chk($sformatf("v%0d_wdata_hold", k), 32'(spi_wdata), 32'(e.wd));
        spi_rdata    = v.srd;
        receive_data = 1'b1;
        @(negedge P_clk);
        receive_data = 1'b0;
        spi_rdata    = ~v.srd;
        chk($sformatf("v%0d_done", k), 32'(done), 32'(e.gnt));
        chk($sformatf("v%0d_rdata", k), 32'(rdata), 32'(e.rd));
        @(negedge P_clk);
        chk($sformatf("v%0d_done_clr", k), 32'(done), 32'd0);
        chk($sformatf("v%0d_gnt_clr", k), 32'(gnt), 32'd0);
        chk($sformatf("v%0d_rdata_hold", k), 32'(rdata), 32'(e.rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // round-robin with all four requesting, then mixed patterns
        vecs[0]  = '{4'b1111, 32'h44332211, 8'hC0, 2,  4'b0001, 8'h11};
        vecs[1]  = '{4'b1111, 32'h45342312, 8'hC1, 3,  4'b0010, 8'h23};
        vecs[2]  = '{4'b1111, 32'h46352413, 8'hC2, 4,  4'b0100, 8'h35};
        vecs[3]  = '{4'b1111, 32'h47362514, 8'hC3, 5,  4'b1000, 8'h47};
        vecs[4]  = '{4'b1111, 32'h48372615, 8'hC4, 6,  4'b0001, 8'h15};
        vecs[5]  = '{4'b1111, 32'h49382716, 8'hC5, 7,  4'b0010, 8'h27};
        vecs[6]  = '{4'b1111, 32'h4A392817, 8'hC6, 8,  4'b0100, 8'h39};
        vecs[7]  = '{4'b1111, 32'h4B3A2918, 8'hC7, 9,  4'b1000, 8'h4B};
        vecs[8]  = '{4'b0001, 32'h000000A5, 8'h3C, 32, 4'b0001, 8'hA5};
        vecs[9]  = '{4'b1010, 32'hDEADBEEF, 8'h5A, 5,  4'b0010, 8'hBE};
        vecs[10] = '{4'b1010, 32'h01020304, 8'h81, 1,  4'b1000, 8'h01};
        vecs[11] = '{4'b0110, 32'h01020304, 8'h7E, 0,  4'b0010, 8'h03};
        vecs[12] = '{4'b0101, 32'h01020304, 8'h00, 3,  4'b0100, 8'h02};

        P_rst        = 1'b0;
        arb_en       = 1'b1;
        req          = '0;
        req_wdata    = '0;
        tip          = 1'b0;
        receive_data = 1'b0;
        spi_rdata    = '0;
        repeat (3) @(negedge P_clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wdata", 32'(spi_wdata), 32'd0);
        chk("rst_send", 32'(send_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        P_rst = 1'b1;
        @(negedge P_clk);

        for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

        // stray receive_data while idle must be ignored
        req          = '0;
        @(negedge P_clk);
        spi_rdata    = 8'hEE;
        receive_data = 1'b1;
        @(negedge P_clk);
        receive_data = 1'b0;
        @(negedge P_clk);
        chk("stray_done", 32'(done), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_rdata", 32'(rdata), 32'h00);

        // arb_en low blocks new grants
        arb_en = 1'b0;
        req    = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge P_clk);
            chk("arb_dis_gnt", 32'(gnt), 32'd0);
            chk("arb_dis_busy", 32'(busy), 32'd0);
        end
        arb_en = 1'b1;

        // dropped request and drain gate on tip
        wait_send("drop_start");
        chk("drop_gnt", 32'(gnt), 32'b0100);
        tip = 1'b1;
        @(negedge P_clk);
        req = 4'b0001;
        repeat (3) @(negedge P_clk);
        chk("drop_gnt_held", 32'(gnt), 32'b0100);
        spi_rdata    = 8'h66;
        receive_data = 1'b1;
        @(negedge P_clk);
        receive_data = 1'b0;
        chk("drop_done", 32'(done), 32'b0100);
        chk("drop_rdata", 32'(rdata), 32'h66);
        for (int i = 0; i < 5; i++) begin
            @(negedge P_clk);
            chk("drain_done", 32'(done), 32'd0);
            chk("drain_gnt", 32'(gnt), 32'd0);
            chk("drain_send", 32'(send_data), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
        end
        tip = 1'b0;
        @(negedge P_clk);
        chk("drain_idle_send", 32'(send_data), 32'd0);
        chk("drain_idle_gnt", 32'(gnt), 32'd0);
        chk("drain_idle_busy", 32'(busy), 32'd0);
        @(negedge P_clk);
        chk("drain_next_send", 32'(send_data), 32'd1);
        chk("drain_next_gnt", 32'(gnt), 32'b0001);
        @(negedge P_clk);
        spi_rdata    = 8'h99;
        receive_data = 1'b1;
        @(negedge P_clk);
        receive_data = 1'b0;
        req          = '0;
        chk("drain_next_done", 32'(done), 32'b0001);
        chk("drain_next_rdata", 32'(rdata), 32'h99);
        repeat (3) @(negedge P_clk);

        // reset in the middle of WAIT
        req       = 4'b0010;
        req_wdata = 32'h00007711;
        wait_send("rst_mid_start");
        chk("rst_mid_gnt", 32'(gnt), 32'b0010);
        repeat (2) @(negedge P_clk);
        P_rst = 1'b0;
        #1;
        chk("rst_mid_gnt0", 32'(gnt), 32'd0);
        chk("rst_mid_done0", 32'(done), 32'd0);
        chk("rst_mid_err0", 32'(err), 32'd0);
        chk("rst_mid_rdata0", 32'(rdata), 32'd0);
        chk("rst_mid_wdata0", 32'(spi_wdata), 32'd0);
        chk("rst_mid_send0", 32'(send_data), 32'd0);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        @(negedge P_clk);
        P_rst = 1'b1;
        req   = 4'b0011;
        wait_send("rst_after_start");
        chk("rst_after_gnt", 32'(gnt), 32'b0001);
        chk("rst_after_wdata", 32'(spi_wdata), 32'h11);
        @(negedge P_clk);
        spi_rdata    = 8'h42;
        receive_data = 1'b1;
        @(negedge P_clk);
        receive_data = 1'b0;
        req          = '0;
        chk("rst_after_done", 32'(done), 32'b0001);
        repeat (3) @(negedge P_clk);

`ifdef SPI_ARB_TIMEOUT_EN
        // no receive_data: err after 100 cycles in WAIT, no done
        req = 4'b0001;
        wait_send("to_start");
        for (int i = 1; i <= 100; i++) begin
            @(negedge P_clk);
            chk("to_err_early", 32'(err), 32'd0);
            chk("to_done_none", 32'(done), 32'd0);
        end
        @(negedge P_clk);
        chk("to_err", 32'(err), 32'b0001);
        chk("to_gnt_clr", 32'(gnt), 32'd0);
        chk("to_done", 32'(done), 32'd0);
        req = '0;
        @(negedge P_clk);
        chk("to_err_once", 32'(err), 32'd0);
        repeat (2) @(negedge P_clk);
        chk("to_idle_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
